// File: rtl/ras_ckpt_pkg.sv
// Shared return-address-stack types: default geometry,
// checkpoint bundle for ROB/BRU recovery, and op codes.
package ras_ckpt_pkg;

    localparam int RAS_DEPTH        = 8;
    localparam int RAS_TARGET_WIDTH = 12;
    localparam int LOG_RAS_DEPTH    = $clog2(RAS_DEPTH);

    typedef struct packed {
        logic [LOG_RAS_DEPTH-1:0] index;
        logic [LOG_RAS_DEPTH:0]   count;
    } ras_ckpt_t;

    typedef enum logic [2:0] {
        RAS_IDLE,
        RAS_PUSH,
        RAS_POP,
        RAS_REPL,
        RAS_RESTORE
    } ras_op_e;

endpackage

// File: rtl/ras_ckpt.sv
// Circular, checkpointable return address stack with saturating
// occupancy and single-cycle restore for mispredict recovery.
module ras_ckpt
    import ras_ckpt_pkg::*;
#(
    parameter int DEPTH        = RAS_DEPTH,
    parameter int TARGET_WIDTH = RAS_TARGET_WIDTH,
    parameter int LOG_DEPTH    = $clog2(DEPTH)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    push_valid,
    input  logic [TARGET_WIDTH-1:0] push_target,
    input  logic                    pop_valid,
    input  logic                    restore_valid,
    input  logic [LOG_DEPTH-1:0]    restore_index,
    input  logic [LOG_DEPTH:0]      restore_count,
    output logic [TARGET_WIDTH-1:0] top_target,
    output logic                    top_valid,
    output logic [LOG_DEPTH-1:0]    ckpt_index,
    output logic [LOG_DEPTH:0]      ckpt_count
);

    localparam logic [LOG_DEPTH:0] FULL = (LOG_DEPTH + 1)'(DEPTH);

    logic [TARGET_WIDTH-1:0] stack [DEPTH];
    logic [LOG_DEPTH-1:0]    sp;
    logic [LOG_DEPTH:0]      count;

    logic [LOG_DEPTH-1:0]    sp_nxt;
    logic [LOG_DEPTH:0]      count_nxt;
    logic                    wr_en;
    logic [LOG_DEPTH-1:0]    wr_idx;
    logic [LOG_DEPTH:0]      rst_cnt;
    logic                    nonempty;
    logic                    full;
    ras_op_e                 op;

    assign nonempty = (count != '0);
    assign full     = (count == FULL);
    // Illegal checkpoint counts are clamped rather than trusted.
    assign rst_cnt  = (restore_count > FULL) ? FULL : restore_count;

    always_comb begin
        op = RAS_IDLE;
        unique case (1'b1)
            restore_valid:
                op = RAS_RESTORE;
            !restore_valid && push_valid && pop_valid && nonempty:
                op = RAS_REPL;
            !restore_valid && push_valid && !(pop_valid && nonempty):
                op = RAS_PUSH;
            !restore_valid && !push_valid && pop_valid && nonempty:
                op = RAS_POP;
            default:
                op = RAS_IDLE;
        endcase
    end

    always_comb begin
        sp_nxt    = sp;
        count_nxt = count;
        wr_en     = 1'b0;
        wr_idx    = sp;
        unique case (op)
            RAS_RESTORE: begin
                sp_nxt    = restore_index;
                count_nxt = rst_cnt;
            end
            RAS_PUSH: begin
                sp_nxt    = sp + 1'b1;
                count_nxt = full ? count : count + 1'b1;
                wr_en     = 1'b1;
                wr_idx    = sp + 1'b1;
            end
            RAS_POP: begin
                sp_nxt    = sp - 1'b1;
                count_nxt = count - 1'b1;
            end
            RAS_REPL: begin
                wr_en  = 1'b1;
                wr_idx = sp;
            end
            default: begin
                sp_nxt    = sp;
                count_nxt = count;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sp    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            sp    <= sp_nxt;
            count <= count_nxt;
            if (wr_en) begin
                stack[wr_idx] <= push_target;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && restore_valid) begin
            assert (restore_count <= FULL);
        end
    end

    assign top_target = stack[sp];
    assign top_valid  = nonempty;
    assign ckpt_index = sp;
    assign ckpt_count = count;

endmodule

// File: tb/tb_ras_ckpt.sv
// Scoreboard bench for ras_ckpt: directed ops queue expected
// post-edge state, a negedge monitor pops and compares.
module tb_ras_ckpt;
    import ras_ckpt_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        push_valid;
    logic [11:0] push_target;
    logic        pop_valid;
    logic        restore_valid;
    logic [2:0]  restore_index;
    logic [3:0]  restore_count;
    logic [11:0] top_target;
    logic        top_valid;
    logic [2:0]  ckpt_index;
    logic [3:0]  ckpt_count;

    ras_ckpt dut (
        .CLK           (CLK),
        .RST           (RST),
        .push_valid    (push_valid),
        .push_target   (push_target),
        .pop_valid     (pop_valid),
        .restore_valid (restore_valid),
        .restore_index (restore_index),
        .restore_count (restore_count),
        .top_target    (top_target),
        .top_valid     (top_valid),
        .ckpt_index    (ckpt_index),
        .ckpt_count    (ckpt_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        int          due;
        logic [11:0] top;
        logic        vld;
        logic [2:0]  idx;
        logic [3:0]  cnt;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        while (q.size() != 0 && q[0].due == cyc) begin
            exp_t e;
            e = q.pop_front();
            n_chk++;
            if ({top_target, top_valid, ckpt_index, ckpt_count}
                !== {e.top, e.vld, e.idx, e.cnt}) begin
                n_fail++;
                $display("FAIL %s: got top=%h v=%b idx=%0d cnt=%0d, exp top=%h v=%b idx=%0d cnt=%0d",
                         e.name, top_target, top_valid, ckpt_index, ckpt_count,
                         e.top, e.vld, e.idx, e.cnt);
            end
        end
    end

    task automatic step(input logic r, input logic ps, input logic pp,
                        input logic rv, input logic [11:0] tgt,
                        input logic [2:0] ri, input logic [3:0] rc,
                        input string nm, input logic [11:0] et,
                        input logic ev, input logic [2:0] ei,
                        input logic [3:0] ec);
        exp_t e;
        @(posedge CLK);
        #1;
        RST           = r;
        push_valid    = ps;
        pop_valid     = pp;
        restore_valid = rv;
        push_target   = tgt;
        restore_index = ri;
        restore_count = rc;
        e.name = nm;
        e.due  = cyc + 1;
        e.top  = et;
        e.vld  = ev;
        e.idx  = ei;
        e.cnt  = ec;
        q.push_back(e);
    endtask

    task automatic do_rst(input string nm);
        step(1, 0, 0, 0, 12'h0, 3'd0, 4'd0, nm, 12'h0, 0, 3'd0, 4'd0);
    endtask

    task automatic do_push(input logic [11:0] t, input string nm,
                           input logic [11:0] et, input logic [2:0] ei,
                           input logic [3:0] ec);
        step(0, 1, 0, 0, t, 3'd0, 4'd0, nm, et, ec != 0, ei, ec);
    endtask

    task automatic do_pop(input string nm, input logic [11:0] et,
                          input logic [2:0] ei, input logic [3:0] ec);
        step(0, 0, 1, 0, 12'h0, 3'd0, 4'd0, nm, et, ec != 0, ei, ec);
    endtask

    logic [11:0] pop_top [8] = '{12'h009, 12'h008, 12'h007, 12'h006,
                                 12'h005, 12'h004, 12'h003, 12'h00A};

    initial begin
        RST = 1; push_valid = 0; pop_valid = 0; restore_valid = 0;
        push_target = '0; restore_index = '0; restore_count = '0;

        do_rst("reset");
        step(0, 0, 0, 0, 12'h0, 3'd0, 4'd0, "idle", 12'h0, 0, 3'd0, 4'd0);
        do_push(12'h111, "push111", 12'h111, 3'd1, 4'd1);
        do_push(12'h222, "push222", 12'h222, 3'd2, 4'd2);
        do_push(12'h333, "push333", 12'h333, 3'd3, 4'd3);
        do_pop("pop1", 12'h222, 3'd2, 4'd2);
        do_pop("pop2", 12'h111, 3'd1, 4'd1);
        do_pop("pop3", 12'h000, 3'd0, 4'd0);
        do_pop("pop_empty", 12'h000, 3'd0, 4'd0);

        do_rst("reset_wrap");
        for (int i = 1; i <= 10; i++) begin
            do_push(12'(i), $sformatf("wrap_push%0d", i), 12'(i),
                    3'(i % 8), 4'(i > 8 ? 8 : i));
        end
        for (int j = 1; j <= 8; j++) begin
            do_pop($sformatf("wrap_pop%0d", j), pop_top[j-1],
                   3'((2 - j) & 7), 4'(8 - j));
        end

        do_rst("reset_repl");
        do_push(12'h0AA, "pushAA", 12'h0AA, 3'd1, 4'd1);
        step(0, 1, 1, 0, 12'h0BB, 3'd0, 4'd0, "repl", 12'h0BB, 1, 3'd1, 4'd1);
        do_rst("reset_repl0");
        step(0, 1, 1, 0, 12'h0CC, 3'd0, 4'd0, "repl_empty", 12'h0CC, 1, 3'd1, 4'd1);

        do_rst("reset_ckpt");
        do_push(12'h100, "push100", 12'h100, 3'd1, 4'd1);
        do_push(12'h200, "ckpt_pt", 12'h200, 3'd2, 4'd2);
        do_push(12'h300, "push300", 12'h300, 3'd3, 4'd3);
        do_pop("ck_pop1", 12'h200, 3'd2, 4'd2);
        do_pop("ck_pop2", 12'h100, 3'd1, 4'd1);
        step(0, 0, 0, 1, 12'h0, 3'd2, 4'd2, "restore22", 12'h200, 1, 3'd2, 4'd2);
        step(0, 1, 1, 1, 12'h7FF, 3'd1, 4'd1, "restore_prio", 12'h100, 1, 3'd1, 4'd1);
        step(0, 0, 0, 1, 12'h0, 3'd3, 4'd0, "restore_empty", 12'h300, 0, 3'd3, 4'd0);
        step(0, 0, 0, 1, 12'h0, 3'd7, 4'd8, "restore_full", 12'h000, 1, 3'd7, 4'd8);

        step(1, 1, 0, 1, 12'h555, 3'd3, 4'd3, "rst_wins", 12'h0, 0, 3'd0, 4'd0);
        step(0, 0, 0, 1, 12'h0, 3'd1, 4'd1, "rst_cleared", 12'h000, 1, 3'd1, 4'd1);
        step(0, 0, 0, 0, 12'h0, 3'd0, 4'd0, "idle_end", 12'h000, 1, 3'd1, 4'd1);

        for (int k = 0; k < 10 && q.size() != 0; k++) @(posedge CLK);
        @(negedge CLK);
        #1;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, exp 0", q.size());
        end
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
